// File: rtl/uart_ex.sv
`default_nettype none
// ============================================================================
// Module   : uart_ex (with helper uart_ex_fifo)
// Brief    : UART with a runtime baud divisor, 16x oversampling, optional
//            even/odd parity, 1 or 2 stop bits, and TX/RX FIFOs. The RX FIFO
//            uses first-word-fall-through.
// Revision : 1.0  initial release
// ============================================================================

// Synchronous FIFO. It has one extra pointer bit so that full and empty can
// be told apart. Its read data is the head word, or zero while it is empty.
module uart_ex_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [ADDR_W:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_wr, do_rd;

  // Flags and pointer updates. A write to a full FIFO goes ahead only when a
  // read frees the head slot in the same cycle.
  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
             (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    do_wr  = wr && (!full || rd);
    do_rd  = rd && !empty;
    wptr_d = do_wr ? wptr_q + (ADDR_W+1)'(1) : wptr_q;
    rptr_d = do_rd ? rptr_q + (ADDR_W+1)'(1) : rptr_q;
    rdata  = empty ? '0 : mem_q[rptr_q[ADDR_W-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array. It has no reset because the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[ADDR_W-1:0]] <= wdata;
  end
endmodule

module uart_ex #(
  parameter int DBIT     = 8,
  parameter int FIFO_W   = 4,
  parameter int DVSR_BIT = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic [1:0]          parity_mode,
  input  logic                stop2,
  input  logic                rx,
  output logic                tx,
  input  logic                wr_uart,
  input  logic [7:0]          w_data,
  output logic                tx_full,
  output logic                tx_idle,
  input  logic                rd_uart,
  output logic                rx_empty,
  output logic [7:0]          r_data,
  output logic [1:0]          r_err,
  output logic                overrun,
  input  logic                clr_ovr
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // ---------------- oversampling tick ----------------
  logic [DVSR_BIT-1:0] tcnt_q, tcnt_d;
  logic                tick;

  // A tick is one cycle wide every dvsr+1 clocks. Using >= recovers cleanly if dvsr shrinks.
  always_comb begin
    tick   = (tcnt_q >= dvsr);
    tcnt_d = tick ? '0 : tcnt_q + DVSR_BIT'(1);
  end

  // ---------------- RX path ----------------
  logic [1:0]        sync_q, sync_d;
  logic              rx_s;
  state_e            rx_state_q, rx_state_d;
  logic [3:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_n_q, rx_n_d;
  logic [DBIT-1:0]   rx_b_q, rx_b_d;
  logic [1:0]        rx_pm_q, rx_pm_d;
  logic              rx_perr_q, rx_perr_d;
  logic              rx_done, rx_full;
  logic [DBIT+1:0]   rx_head;
  logic              overrun_q, overrun_d;

  // The RX receiver runs at 16x oversampling. The start bit is confirmed at
  // mid-bit, and every later bit is sampled 16 ticks after the previous one.
  always_comb begin
    sync_d     = {sync_q[0], rx};
    rx_s       = sync_q[1];
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_pm_d    = rx_pm_q;
    rx_perr_d  = rx_perr_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (!rx_s) begin
        rx_state_d = ST_START;
        rx_cnt_d   = '0;
        rx_pm_d    = parity_mode;
        rx_perr_d  = 1'b0;
      end
      ST_START: if (tick) begin
        if (rx_cnt_q == 4'd7) begin
          rx_cnt_d   = '0;
          rx_n_d     = '0;
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      ST_DATA: if (tick) begin
        if (rx_cnt_q == 4'd15) begin
          rx_cnt_d = '0;
          rx_b_d   = {rx_s, rx_b_q[DBIT-1:1]};
          if (rx_n_q == 3'(DBIT-1))
            rx_state_d = (rx_pm_q[0] ^ rx_pm_q[1]) ? ST_PARITY : ST_STOP;
          else rx_n_d = rx_n_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      ST_PARITY: if (tick) begin
        if (rx_cnt_q == 4'd15) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_s ^ (^rx_b_q) ^ rx_pm_q[1];
          rx_state_d = ST_STOP;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      ST_STOP: if (tick) begin
        if (rx_cnt_q == 4'd15) begin
          rx_state_d = ST_IDLE;
          rx_done    = 1'b1;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
    overrun_d = (rx_done && rx_full) ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
  end

  // RX state registers. The synchroniser resets to the line's idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      rx_pm_q    <= '0;
      rx_perr_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      rx_pm_q    <= rx_pm_d;
      rx_perr_q  <= rx_perr_d;
      overrun_q  <= overrun_d;
    end
  end

  uart_ex_fifo #(.WIDTH(DBIT+2), .ADDR_W(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n),
    .wr(rx_done), .wdata({~rx_s, rx_perr_q, rx_b_q}),
    .rd(rd_uart), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- TX path ----------------
  state_e            tx_state_q, tx_state_d;
  logic [4:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_n_q, tx_n_d;
  logic [DBIT-1:0]   tx_b_q, tx_b_d;
  logic              tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
  logic              tx_stop2_q, tx_stop2_d;
  logic              tx_q, tx_d;
  logic              tx_pop, tx_empty;
  logic [DBIT-1:0]   tx_head;

  // The TX serializer. Frame settings and the parity bit are captured when the head word is popped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_stop2_d = tx_stop2_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_b_d     = tx_head;
          tx_par_d   = (^tx_head) ^ parity_mode[1];
          tx_pen_d   = parity_mode[0] ^ parity_mode[1];
          tx_stop2_d = stop2;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: if (tick) begin
        if (tx_cnt_q == 5'd15) begin
          tx_cnt_d   = '0;
          tx_n_d     = '0;
          tx_d       = tx_b_q[0];
          tx_state_d = ST_DATA;
        end else tx_cnt_d = tx_cnt_q + 5'd1;
      end
      ST_DATA: if (tick) begin
        if (tx_cnt_q == 5'd15) begin
          tx_cnt_d = '0;
          tx_b_d   = tx_b_q >> 1;
          if (tx_n_q == 3'(DBIT-1)) begin
            tx_state_d = tx_pen_q ? ST_PARITY : ST_STOP;
            tx_d       = tx_pen_q ? tx_par_q : 1'b1;
          end else begin
            tx_n_d = tx_n_q + 3'd1;
            tx_d   = tx_b_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 5'd1;
      end
      ST_PARITY: if (tick) begin
        if (tx_cnt_q == 5'd15) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = ST_STOP;
        end else tx_cnt_d = tx_cnt_q + 5'd1;
      end
      ST_STOP: if (tick) begin
        if (tx_cnt_q == (tx_stop2_q ? 5'd31 : 5'd15)) begin
          tx_d       = 1'b1;
          tx_state_d = ST_IDLE;
        end else tx_cnt_d = tx_cnt_q + 5'd1;
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // TX state registers and the tick counter. The line output is registered to avoid glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q     <= '0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tcnt_q     <= tcnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_stop2_q <= tx_stop2_d;
      tx_q       <= tx_d;
    end
  end

  uart_ex_fifo #(.WIDTH(DBIT), .ADDR_W(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n),
    .wr(wr_uart), .wdata(w_data[DBIT-1:0]),
    .rd(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // Output mapping. Received data is zero-extended to a byte.
  always_comb begin
    tx      = tx_q;
    tx_idle = tx_empty && (tx_state_q == ST_IDLE);
    r_data  = 8'(rx_head[DBIT-1:0]);
    r_err   = rx_head[DBIT+1:DBIT];
    overrun = overrun_q;
  end
endmodule
`default_nettype wire

// File: doc/uart_ex.md
UART_EX -- requirements
Module: uart_ex

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame, legal 5..8.
REQ-002 Parameter FIFO_W, default 4, address bits per FIFO; depth 2^FIFO_W words.
REQ-003 Parameter DVSR_BIT, default 11, width of runtime baud divisor.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 dvsr  input  DVSR_BIT  baud divisor; tick period = dvsr+1 clocks; 16 ticks per bit.
REQ-007 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 stop2  input  1  0: one stop bit (16 ticks), 1: two stop bits (32 ticks).
REQ-009 rx  input  1  serial input, asynchronous to clk.
REQ-010 tx  output  1  serial output, idle high.
REQ-011 wr_uart  input  1  push w_data into TX FIFO.
REQ-012 w_data  input  8  TX word; bits above DBIT-1 ignored.
REQ-013 tx_full  output  1  TX FIFO full.
REQ-014 tx_idle  output  1  TX FIFO empty and TX FSM idle.
REQ-015 rd_uart  input  1  pop RX FIFO head.
REQ-016 rx_empty  output  1  RX FIFO empty.
REQ-017 r_data  output  8  RX FIFO head data, first-word-fall-through; bits above DBIT-1 zero.
REQ-018 r_err  output  2  head word errors {frame_err, parity_err}.
REQ-019 overrun  output  1  sticky: received word dropped because RX FIFO full.
REQ-020 clr_ovr  input  1  clears overrun.

Function
REQ-021 Tick generator: counter 0..dvsr, single-cycle tick when count>=dvsr, then count returns to 0; dvsr=0 gives tick every clock.
REQ-022 rx passes a 2-flop synchroniser (reset value 1) before the RX FSM.
REQ-023 parity_mode, stop2 are latched per frame: TX on leaving idle, RX on start-edge detect; mid-frame changes do not affect the current frame.
REQ-024 RX FSM states idle, start, data, parity, stop; idle->start on synchronised rx=0.
REQ-025 start: at 8th tick, rx=0 -> data with tick count cleared; rx=1 -> idle, nothing pushed (glitch rejection).
REQ-026 data: sample every 16th tick, LSB first, DBIT bits; then parity if enabled, else stop.
REQ-027 parity: sample at 16th tick; parity_err=1 when received bit differs from even/odd parity of data.
REQ-028 stop: sample first stop bit at 16th tick; frame_err=1 if 0; return to idle same cycle; second stop bit not checked.
REQ-029 Frame completion pushes {frame_err, parity_err, data} into RX FIFO in one cycle.
REQ-030 RX FIFO full at completion: word dropped, overrun set; set wins over simultaneous clr_ovr.
REQ-031 TX FSM states idle, start, data, parity, stop; idle->start when TX FIFO non-empty, popping head into shift register that cycle.
REQ-032 tx drives 0 for 16 ticks (start), DBIT data bits LSB first 16 ticks each, parity bit 16 ticks if enabled, 1 for 16 or 32 ticks (stop); then idle, next frame may start next clock.
REQ-033 FIFOs: write when full ignored (tx_full unchanged); read when empty ignored; full with rd&wr performs both; empty with rd&wr performs write only.
REQ-034 Pointers wrap modulo 2^FIFO_W; full/empty flags correct across wrap.
REQ-035 r_data, r_err are 0 while rx_empty=1.

Reset
REQ-036 reset_n=0 asynchronously: both FSMs idle, tick counter 0, FIFOs empty, tx=1, tx_full=0, tx_idle=1, rx_empty=1, r_data=0, r_err=0, overrun=0.
REQ-037 Reset mid-frame aborts the frame; partial words are neither pushed nor transmitted; operation resumes on first clock after release.

Verification
REQ-038 dvsr=0, DBIT=8, no parity, stop2=0, write 0xA5 -> tx: 0 for 16 clk, 1,0,1,0,0,1,0,1 at 16 clk each, 1 for 16 clk; tx_idle returns 1.
REQ-039 Loopback tx->rx, parity_mode=01, write 0x00,0xFF,0x5A -> RX reads same values in order, r_err=00 each.
REQ-040 Drive 0x37 with odd parity bit inverted and stop bit 0 under parity_mode=10 -> r_data=0x37, r_err=11.
REQ-041 rx low pulse of 4 ticks -> no push, rx_empty stays 1.
REQ-042 FIFO_W=2, receive 5 frames without reading -> 4 words held, overrun=1; clr_ovr -> overrun=0; wr_uart on full TX FIFO ignored.
REQ-043 Assert reset_n=0 during TX data bit 3 -> tx=1 immediately, tx_idle=1, no residual frame after release.
